// File: rtl/carry60s_pkg.sv
// Shared constants for the 60 s count-up/countdown timers.
package carry60s_pkg;

  localparam logic [3:0] SEC_MAX_TENS = 4'd5;
  localparam logic [3:0] SEC_MAX_ONES = 4'd9;
  localparam logic [7:0] BCD_ZERO     = 8'h00;
  localparam logic [7:0] BCD_59       = 8'h59;

  function automatic logic bcd_sec_ok(input logic [7:0] v);
    return (v[7:4] <= SEC_MAX_TENS) && (v[3:0] <= SEC_MAX_ONES);
  endfunction

endpackage

// File: rtl/carry60s_tick.sv
// Prescaler: one-cycle tick every CLK_DIV enabled cycles.
module carry60s_tick #(
  parameter int CLK_DIV = 50_000_000,
  parameter int CNT_W   = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = en & ~clr & w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/carry60s_top.sv
// BCD seconds counter 00..59 with preset and wrap carry.
module carry60s_top
  import carry60s_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000,
  parameter int CNT_W   = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cnt_en,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] x,
  output logic       carry
);

  logic [7:0] r_x;
  logic       r_carry;
  logic       w_tick;
  logic [7:0] w_x_nxt;
  logic       w_carry_nxt;

  carry60s_tick #(
    .CLK_DIV(CLK_DIV),
    .CNT_W  (CNT_W)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (cnt_en),
    .clr  (load),
    .tick (w_tick)
  );

  // tick is already masked by load, so the arms are exclusive
  always_comb begin
    w_x_nxt     = r_x;
    w_carry_nxt = 1'b0;
    unique case (1'b1)
      load: begin
        w_x_nxt = bcd_sec_ok(load_val) ? load_val : BCD_ZERO;
      end
      w_tick: begin
        if (r_x[3:0] < SEC_MAX_ONES) begin
          w_x_nxt[3:0] = r_x[3:0] + 4'd1;
        end else if (r_x[7:4] < SEC_MAX_TENS) begin
          w_x_nxt = {r_x[7:4] + 4'd1, 4'd0};
        end else begin
          w_x_nxt     = BCD_ZERO;
          w_carry_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= BCD_ZERO;
      r_carry <= 1'b0;
    end else begin
      r_x     <= w_x_nxt;
      r_carry <= w_carry_nxt;
    end
  end

  assign x     = r_x;
  assign carry = r_carry;

endmodule
